// File: rtl/cpu_control_unit.sv
// cpu_control_unit: fetch/decode/execute sequencer driving the 8-bit CPU datapath strobes
module cpu_control_unit (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic [3:0] opcode,
    input  logic       zero_flag,
    input  logic       carry_flag,
    output logic       mar_load,
    output logic       mar_sel_pc,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic       ir_load,
    output logic       pc_inc,
    output logic       pc_load,
    output logic       b_load,
    output logic       acc_load,
    output logic [1:0] acc_sel,
    output logic       alu_sub,
    output logic       flags_load,
    output logic       out_load,
    output logic       halted,
    output logic       illegal,
    output logic [2:0] state
);
    typedef enum logic [2:0] {
        T0   = 3'd0,
        T1   = 3'd1,
        T2   = 3'd2,
        E1   = 3'd3,
        E2   = 3'd4,
        HALT = 3'd7
    } state_t;

    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JZ  = 4'h7;
    localparam logic [3:0] OP_JC  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    state_t cur, nxt;
    logic   mem_op, alu_op, undef;

    assign alu_op = (opcode == OP_ADD) || (opcode == OP_SUB);
    assign mem_op = alu_op || (opcode == OP_LDA) || (opcode == OP_STA);
    assign undef  = (opcode >= 4'h9) && (opcode <= 4'hD);
    assign state  = rst ? cur : 3'd0;

    // next-state decode; unreachable encodings fall back to T0
    always_comb begin
        case (cur)
            T0:      nxt = T1;
            T1:      nxt = T2;
            T2:      nxt = mem_op ? E1 : (opcode == OP_HLT) ? HALT : T0;
            E1:      nxt = alu_op ? E2 : T0;
            HALT:    nxt = HALT;
            default: nxt = T0;
        endcase
    end

    // state register: reset wins over everything, run=0 freezes the step
    always_ff @(posedge clk) begin
        if (!rst)
            cur <= T0;
        else if (run)
            cur <= nxt;
    end

    // Moore strobe decode, silenced while in reset or stalled
    always_comb begin
        mar_load   = 1'b0;
        mar_sel_pc = 1'b0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        ir_load    = 1'b0;
        pc_inc     = 1'b0;
        pc_load    = 1'b0;
        b_load     = 1'b0;
        acc_load   = 1'b0;
        acc_sel    = 2'd0;
        alu_sub    = 1'b0;
        flags_load = 1'b0;
        out_load   = 1'b0;
        illegal    = 1'b0;
        halted     = rst && (cur == HALT);
        if (rst && run) begin
            case (cur)
                T0: begin
                    mar_load   = 1'b1;
                    mar_sel_pc = 1'b1;
                end
                T1: begin
                    mem_rd  = 1'b1;
                    ir_load = 1'b1;
                    pc_inc  = 1'b1;
                end
                T2: begin
                    mar_load = mem_op;
                    acc_load = (opcode == OP_LDI);
                    acc_sel  = (opcode == OP_LDI) ? 2'd1 : 2'd0;
                    pc_load  = (opcode == OP_JMP) || ((opcode == OP_JZ) && zero_flag)
                            || ((opcode == OP_JC) && carry_flag);
                    out_load = (opcode == OP_OUT);
                    illegal  = undef;
                end
                E1: begin
                    mem_rd   = alu_op || (opcode == OP_LDA);
                    acc_load = (opcode == OP_LDA);
                    b_load   = alu_op;
                    mem_wr   = (opcode == OP_STA);
                end
                E2: begin
                    acc_load   = 1'b1;
                    acc_sel    = 2'd2;
                    alu_sub    = (opcode == OP_SUB);
                    flags_load = 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule
